// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire slice: ALU control codes,
// default widths and the layout of one captured result entry.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 4;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    // One result FIFO entry; the top packs its flat FIFO word in this order.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
        logic                  cout;
        logic                  overflow;
        logic [ALU_TAG_W-1:0]  tag;
    } result_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO with a combinational head view and an occupancy
// count. Pointers wrap explicitly so non-power-of-two depths also work.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    // A push into a full FIFO is only taken if the head leaves on the same edge.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Entry storage; cleared on reset so the head reads zero until first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire stage in front of a one-cycle registered ALU. Requests are
// registered onto the ALU inputs, a two-stage valid/tag shadow tracks the
// ALU latency, and results are captured into a result FIFO. in_ready reserves
// a FIFO slot for every op still in flight so no result can ever be dropped.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int TAG_W  = ALU_TAG_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [3:0]        in_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_cout,
    output logic              out_overflow,
    output logic [TAG_W-1:0]  out_tag,
    output logic [31:0]       ops_cnt
);

    localparam int ENTRY_W = DATA_W + 3 + TAG_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int CRED_W  = CNT_W + 2;

    logic               accept;
    logic               push;
    logic               pop;
    logic               s1_valid;
    logic               s2_valid;
    logic [TAG_W-1:0]   s1_tag;
    logic [TAG_W-1:0]   s2_tag;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W-1:0]   fifo_count;
    logic [CRED_W-1:0]  inflight;

    // Credit: everything stored or still travelling through the ALU owns a slot.
    assign inflight = CRED_W'(fifo_count) + CRED_W'(s1_valid) + CRED_W'(s2_valid);
    assign in_ready = (inflight < CRED_W'(DEPTH));
    assign accept   = in_valid & in_ready;

    // s2 lines up with the cycle in which the ALU's registered output is valid.
    assign push      = s2_valid;
    assign push_data = {alu_result, alu_zero, alu_cout, alu_overflow, s2_tag};

    assign out_valid    = (fifo_count != '0);
    assign pop          = out_valid & out_ready;
    assign out_result   = head_data[ENTRY_W-1 -: DATA_W];
    assign out_zero     = head_data[TAG_W + 2];
    assign out_cout     = head_data[TAG_W + 1];
    assign out_overflow = head_data[TAG_W];
    assign out_tag      = head_data[TAG_W-1:0];

    // Register accepted operands onto the ALU; hold them when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src1 <= '0;
            alu_src2 <= '0;
            alu_ctrl <= 4'b0000;
            s1_tag   <= '0;
        end else if (accept) begin
            alu_src1 <= in_src1;
            alu_src2 <= in_src2;
            alu_ctrl <= in_ctrl;
            s1_tag   <= in_tag;
        end
    end

    // Track which ALU cycles carry a real op so idle results are never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_tag   <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
        end
    end

    // Count completed pops; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_cnt <= 32'd0;
        end else if (pop) begin
            ops_cnt <= ops_cnt + 32'd1;
        end
    end

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_src1 = 32'd0;
    logic [31:0] in_src2 = 32'd0;
    logic [3:0]  in_ctrl = 4'd0;
    logic [3:0]  in_tag = 4'd0;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero, alu_cout, alu_overflow;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero, out_cout, out_overflow;
    logic [3:0]  out_tag;
    logic [31:0] ops_cnt;
    logic        alu_rst_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    result_entry_t exp_q[$];
    int pop_times[$];
    result_entry_t held;
    logic held_v = 1'b0;

    alu_issue_ctrl #(.DATA_W(32), .TAG_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_ctrl(in_ctrl), .in_tag(in_tag),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_cout(out_cout),
        .out_overflow(out_overflow), .out_tag(out_tag), .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 32-bit registered ALU, reset from ~rst as in the real system.
    function automatic logic [34:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        co, ov;
        r = 32'd0; co = 1'b0; ov = 1'b0; s = 33'd0;
        case (c)
            ALU_CTRL_AND: r = a & b;
            ALU_CTRL_OR:  r = a | b;
            ALU_CTRL_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_CTRL_SUB, ALU_CTRL_SLT: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                co = s[32];
                ov = (a[31] != b[31]) && (s[31] != a[31]);
                r = (c == ALU_CTRL_SLT) ? {31'd0, s[31] ^ ov} : s[31:0];
            end
            ALU_CTRL_NOR: r = ~(a | b);
            default:      r = 32'd0;
        endcase
        return {r, (r == 32'd0), co, ov};
    endfunction

    assign alu_rst_n = ~rst;

    always @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n) {alu_result, alu_zero, alu_cout, alu_overflow} <= 35'd0;
        else {alu_result, alu_zero, alu_cout, alu_overflow} <= alu_eval(alu_src1, alu_src2, alu_ctrl);
    end

    // Credit rule must make a push into a full FIFO impossible.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dut.push && int'(dut.fifo_count) >= DEPTH))
                else $error("FAIL fifo_overflow: push with count %0d", dut.fifo_count);
        end
    end

    function automatic result_entry_t mk(input logic [31:0] r, input logic z, input logic c,
                                         input logic o, input logic [3:0] t);
        result_entry_t e;
        e.result = r; e.zero = z; e.cout = c; e.overflow = o; e.tag = t;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare head on every pop, and check head stability under backpressure.
    always @(negedge clk) begin
        result_entry_t act;
        result_entry_t e;
        act = mk(out_result, out_zero, out_cout, out_overflow, out_tag);
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (!out_valid || act !== held) begin
                    errors++;
                    $display("FAIL head_hold: valid=%0b got 0x%0h expected 0x%0h", out_valid, act, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: got 0x%0h expected no result", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL pop: got 0x%0h expected 0x%0h", act, e);
                    end
                end
                pop_times.push_back(cyc);
                held_v = 1'b0;
            end else if (out_valid) begin
                held = act;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Offer one request; returns after the accepting edge with in_valid still high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [3:0] t, input result_entry_t e, output int waited);
        waited = 0;
        in_valid = 1'b1; in_src1 = a; in_src2 = b; in_ctrl = c; in_tag = t;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready 0 expected 1 for tag %0d", t);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        last_acc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("rst_alu_src1", 64'(alu_src1), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_ops_cnt", 64'(ops_cnt), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Throughput: 16 back-to-back ADDs, i + 0x100
        @(posedge clk); #1;
        out_ready = 1'b1;
        pop_times.delete();
        for (int i = 0; i < 16; i++) begin
            send(32'(i), 32'h100, ALU_CTRL_ADD, 4'(i), mk(32'(i) + 32'h100, 1'b0, 1'b0, 1'b0, 4'(i)), w);
            check("tp_no_stall", 64'(w), 64'd0);
        end
        in_valid = 1'b0;
        drain();
        check("tp_pops", 64'(pop_times.size()), 64'd16);
        for (int i = 1; i < pop_times.size(); i++)
            check("tp_consecutive", 64'(pop_times[i] - pop_times[i-1]), 64'd1);
        check("tp_ops_cnt", 64'(ops_cnt), 64'd16);

        // ADD overflow, latency of two clocks
        @(posedge clk); #1;
        pop_times.delete();
        send(32'h7FFFFFFF, 32'h00000001, ALU_CTRL_ADD, 4'd3, mk(32'h80000000, 1'b0, 1'b0, 1'b1, 4'd3), w);
        base = last_acc;
        in_valid = 1'b0;
        drain();
        check("add_pops", 64'(pop_times.size()), 64'd1);
        if (pop_times.size() > 0) check("add_latency", 64'(pop_times[0] - base), 64'd2);

        // SUB then SLT back to back
        pop_times.delete();
        @(posedge clk); #1;
        send(32'd5, 32'd5, ALU_CTRL_SUB, 4'd1, mk(32'd0, 1'b1, 1'b1, 1'b0, 4'd1), w);
        send(32'hFFFFFFFF, 32'h00000001, ALU_CTRL_SLT, 4'd2, mk(32'd1, 1'b0, 1'b1, 1'b0, 4'd2), w);
        in_valid = 1'b0;
        drain();
        check("subslt_pops", 64'(pop_times.size()), 64'd2);
        if (pop_times.size() == 2) check("subslt_consecutive", 64'(pop_times[1] - pop_times[0]), 64'd1);

        // Backpressure: 4 accepted, tag 4 stalls until the consumer drains
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++)
            send(32'hA0, 32'(t), ALU_CTRL_OR, 4'(t), mk(32'hA0 | 32'(t), 1'b0, 1'b0, 1'b0, 4'(t)), w);
        in_src1 = 32'hA0; in_src2 = 32'd4; in_ctrl = ALU_CTRL_OR; in_tag = 4'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 4; t < 6; t++)
            send(32'hA0, 32'(t), ALU_CTRL_OR, 4'(t), mk(32'hA0 | 32'(t), 1'b0, 1'b0, 1'b0, 4'(t)), w);
        in_valid = 1'b0;
        drain();
        check("bp_ops_cnt", 64'(ops_cnt), 64'd25);

        // Reset mid-flight: 2 entries in FIFO, 2 in the ALU pipeline
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int t = 8; t < 12; t++)
            send(32'(t), 32'd1, ALU_CTRL_ADD, 4'(t), mk(32'(t) + 32'd1, 1'b0, 1'b0, 1'b0, 4'(t)), w);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("mrst_ops_cnt", 64'(ops_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mrst_quiet", 64'(out_valid), 64'd0);
        end
        check("mrst_ops_cnt_after", 64'(ops_cnt), 64'd0);
        @(posedge clk); #1;
        send(32'h0000F0F0, 32'h0000FF00, ALU_CTRL_AND, 4'd7, mk(32'h0000F000, 1'b0, 1'b0, 1'b0, 4'd7), w);
        in_valid = 1'b0;
        drain();
        check("mrst_new_ops_cnt", 64'(ops_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/retire stage placed directly upstream of the 32-bit registered ALU. It feeds that ALU and consumes what it produces.
- Accepts operation requests over a valid/ready handshake, then drives src1/src2/ALU_control into the ALU.
- Tracks the ALU's one-cycle registered latency and captures result plus flags into a result FIFO. The FIFO is drained by a downstream valid/ready consumer, and in-order tags are preserved.
- A credit check guarantees that captured results are never dropped under backpressure.

Parameters:
- DATA_W, 32: operand/result width; must match the ALU.
- TAG_W, 4: width of the request tag carried alongside each op.
- DEPTH, 4: result FIFO entries; minimum 3; 4 or more gives full throughput.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at posedge
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- in_ctrl  in  4  ALU_control code
- in_tag  in  TAG_W  request tag
- alu_src1  out  DATA_W  to ALU src1
- alu_src2  out  DATA_W  to ALU src2
- alu_ctrl  out  4  to ALU ALU_control
- alu_result  in  DATA_W  ALU registered result
- alu_zero  in  1  ALU zero flag
- alu_cout  in  1  ALU carry flag
- alu_overflow  in  1  ALU overflow flag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  DATA_W  head result
- out_zero  out  1  head zero flag
- out_cout  out  1  head carry flag
- out_overflow  out  1  head overflow flag
- out_tag  out  TAG_W  head tag
- ops_cnt  out  32  completed pops, wraps at 2^32

Behaviour:
- Reset values, asserted asynchronously while rst=1:
  - alu_src1=0, alu_src2=0, alu_ctrl=4'b0000.
  - s1_valid=0, s2_valid=0, FIFO empty.
  - out_valid=0, out_* data=0, ops_cnt=0.
  - in_ready=1 once reset deasserts.
- ALU integration: at top level the ALU's rst_n is driven from ~rst.
- Pipeline, for a request accepted at edge E0:
  - E0: operands/ctrl registered onto alu_*, s1_valid=1, tag into s1_tag.
  - E1: ALU samples alu_*; s2_valid=s1_valid, s2_tag=s1_tag.
  - E2: if s2_valid, push {alu_result, alu_zero, alu_cout, alu_overflow, s2_tag} into the FIFO.
  - out_valid is high in the cycle after E2, so latency is 2 clocks from acceptance.
- When no request is accepted: alu_* hold their last values and s1_valid=0. The ALU still computes, but that result is never captured.
- Credit rule: in_ready = (fifo_count + s1_valid + s2_valid) < DEPTH. It is derived from registers only and has no combinational path from in_valid or out_ready.
- FIFO:
  - out_* show the head entry; out_valid = (fifo_count != 0).
  - A pop occurs on out_valid & out_ready.
  - Push and pop may happen on the same edge; count is then unchanged and order is FIFO.
  - Push when full is impossible by the credit rule; the bench asserts this.
- in_ctrl is forwarded unchanged, with no decoding. Legal codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. Other codes are passed through and the result is whatever the ALU produces.
- ops_cnt increments by 1 on each pop and wraps to 0 after 0xFFFFFFFF.
- Reset mid-operation: all in-flight ops and FIFO contents are discarded immediately. No stale result appears after reset release.
- out_valid never drops without a pop. Head data is stable while out_valid & !out_ready.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_CTRL_AND/OR/ADD/SUB/SLT/NOR 4-bit constants.
  - DATA_W default.
  - The result-entry struct {result, zero, cout, overflow, tag}.
- One sub-module: alu_result_fifo, a synchronous FIFO with parameters DEPTH and entry width, count output, async active-high reset. The issue/credit logic stays in the top.

Test Plan:
- ADD: in_src1=0x7FFFFFFF, in_src2=0x00000001, ctrl 0010, tag 3 -> two clocks later out_result=0x80000000, overflow=1, cout=0, zero=0, out_tag=3.
- SUB then SLT back-to-back:
  - SUB: 5-5, ctrl 0110, tag 1 -> result 0, zero=1, cout=1.
  - SLT: 0xFFFFFFFF vs 0x00000001, ctrl 0111, tag 2 -> result 1, zero=0, on the following cycle.
- Backpressure: out_ready=0 with 6 consecutive valid requests (tags 0..5) -> exactly 4 accepted, then in_ready=0. Raising out_ready -> tags 0,1,2,3 popped in order, and in_ready recovers to accept tags 4,5.
- Throughput: 16 back-to-back requests with out_ready=1 and DEPTH=4 -> in_ready never drops, 16 results on consecutive cycles, ops_cnt=16.
- Reset mid-flight: assert rst with 2 ops in flight and 2 in the FIFO -> out_valid=0 and alu_ctrl=0000 immediately. After release, no result appears until a new request is accepted, and ops_cnt=0.
